// File: rtl/scope_capture.sv
// scope_capture: waits for a level/slope trigger on a 12-bit ADC stream,
// fills a shadow buffer with SAMPLES consecutive samples and publishes the
// whole frame on data[] in one edge, followed by a holdoff period.
// Optional feature macro: SCOPE_CAPTURE_TRIG_TIMEOUT_EN (forced trigger after
// TIMEOUT cycles in WAIT_TRIG, reported on auto_trig).
module scope_capture #(
   parameter int unsigned SAMPLES = 512,
   parameter int unsigned DATA_W  = 12,
   parameter int unsigned HOLDOFF = 1000,
   parameter int unsigned TIMEOUT = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic              run,
   input  logic              single,
   output logic [DATA_W-1:0] data [0:SAMPLES-1],
   output logic              frame_valid,
   output logic              busy,
   output logic              auto_trig
);

   localparam int unsigned IDX_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int unsigned HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_TRIG,
      ST_CAPTURE,
      ST_HOLDOFF
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [HO_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              prev_valid_q, prev_valid_d;
   logic              one_shot_q, one_shot_d;
   logic              pub_q, pub_d;
   logic              frame_valid_q, frame_valid_d;
   logic [DATA_W-1:0] shadow_q [0:SAMPLES-1];
   logic [DATA_W-1:0] shadow_d [0:SAMPLES-1];
   logic [DATA_W-1:0] data_q   [0:SAMPLES-1];
   logic [DATA_W-1:0] data_d   [0:SAMPLES-1];

   logic rise_hit, fall_hit, real_trig;

   assign rise_hit  = (prev_q < trig_level) && (adc_data >= trig_level);
   assign fall_hit  = (prev_q > trig_level) && (adc_data <= trig_level);
   assign real_trig = prev_valid_q && (trig_slope ? fall_hit : rise_hit);

`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            forced_q, forced_d;
   logic            auto_trig_q, auto_trig_d;
   logic            to_hit;

   assign to_hit    = (to_cnt_q >= TO_W'(TIMEOUT));
   assign auto_trig = auto_trig_q;
`else
   // No forced-trigger path in this build: auto_trig is constant 0 and
   // TIMEOUT has no effect on behaviour.
   assign auto_trig = 1'b0 & (TIMEOUT != 0);
`endif

   assign data        = data_q;
   assign frame_valid = frame_valid_q;
   assign busy        = (state_q != ST_IDLE);

   // Next-state, capture-buffer and publish logic.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      hold_cnt_d    = hold_cnt_q;
      prev_d        = prev_q;
      prev_valid_d  = prev_valid_q;
      one_shot_d    = one_shot_q;
      pub_d         = 1'b0;
      frame_valid_d = 1'b0;
      shadow_d      = shadow_q;
      data_d        = data_q;
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
      to_cnt_d      = to_cnt_q;
      forced_d      = forced_q;
      auto_trig_d   = auto_trig_q;
`endif

      // Publish one edge after the last shadow write, whatever the state.
      if (pub_q) begin
         data_d        = shadow_q;
         frame_valid_d = 1'b1;
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
         auto_trig_d   = forced_q;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (run || single) begin
               state_d      = ST_WAIT_TRIG;
               one_shot_d   = single;
               prev_valid_d = 1'b0;
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
               to_cnt_d     = '0;
`endif
            end
         end

         ST_WAIT_TRIG: begin
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
            if (!to_hit) to_cnt_d = to_cnt_q + 1'b1;
`endif
            if (!run && !one_shot_q) begin
               state_d    = ST_IDLE;
               one_shot_d = 1'b0;
            end else if (adc_valid) begin
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
               if (real_trig || to_hit) begin
                  forced_d = !real_trig;
`else
               if (real_trig) begin
`endif
                  shadow_d[0] = adc_data;
                  idx_d       = IDX_W'(1);
                  state_d     = ST_CAPTURE;
               end else begin
                  prev_d       = adc_data;
                  prev_valid_d = 1'b1;
               end
            end
         end

         ST_CAPTURE: begin
            if (adc_valid) begin
               shadow_d[idx_q] = adc_data;
               idx_d           = idx_q + 1'b1;
               if (idx_q == IDX_W'(SAMPLES - 1)) begin
                  idx_d      = '0;
                  state_d    = ST_HOLDOFF;
                  hold_cnt_d = '0;
                  pub_d      = 1'b1;
               end
            end
         end

         ST_HOLDOFF: begin
            if (hold_cnt_q == HO_W'(HOLDOFF - 1)) begin
               hold_cnt_d = '0;
               if (run && !one_shot_q) begin
                  state_d      = ST_WAIT_TRIG;
                  prev_valid_d = 1'b0;
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
                  to_cnt_d     = '0;
`endif
               end else begin
                  state_d    = ST_IDLE;
                  one_shot_d = 1'b0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and storage registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         hold_cnt_q    <= '0;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         one_shot_q    <= 1'b0;
         pub_q         <= 1'b0;
         frame_valid_q <= 1'b0;
         for (int unsigned i = 0; i < SAMPLES; i++) begin
            shadow_q[i] <= '0;
            data_q[i]   <= '0;
         end
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
         to_cnt_q      <= '0;
         forced_q      <= 1'b0;
         auto_trig_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         hold_cnt_q    <= hold_cnt_d;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         one_shot_q    <= one_shot_d;
         pub_q         <= pub_d;
         frame_valid_q <= frame_valid_d;
         shadow_q      <= shadow_d;
         data_q        <= data_d;
`ifdef SCOPE_CAPTURE_TRIG_TIMEOUT_EN
         to_cnt_q      <= to_cnt_d;
         forced_q      <= forced_d;
         auto_trig_q   <= auto_trig_d;
`endif
      end
   end

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
- Acquisition stage directly upstream of the waveform-measurement block (Vsk/min/max).
- Accepts a stream of 12-bit ADC samples, waits for a level/slope trigger, and captures SAMPLES consecutive samples into a shadow buffer.
- Publishes the completed frame atomically on a parallel array output, which the measurement block reads continuously.
- Supports continuous and single-shot acquisition, with holdoff between frames.

Parameters:
- SAMPLES, 512: samples per frame; data output is indexed 0..SAMPLES-1.
- DATA_W, 12: sample width; mid-scale/GND code is 2048.
- HOLDOFF, 1000: clk cycles spent in HOLDOFF after each published frame.
- TIMEOUT, 50000000: clk cycles in WAIT_TRIG before a forced trigger (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- adc_data  in  DATA_W  ADC sample
- adc_valid  in  1  adc_data valid this cycle; single-cycle strobe, any rate
- trig_level  in  DATA_W  trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- run  in  1  level; high = continuous acquisition
- single  in  1  pulse; arms one acquisition when idle
- data  out  DATA_W x SAMPLES  published frame, unpacked array [0:SAMPLES-1]
- frame_valid  out  1  one-cycle pulse when data updates
- busy  out  1  high in any state other than IDLE
- auto_trig  out  1  last published frame was force-triggered

Behaviour:
- Reset (clk edge with rst high, regardless of state):
  - state -> IDLE.
  - all data entries, shadow buffer, index, counters and prev sample -> 0.
  - frame_valid, busy, auto_trig -> 0.
- States: IDLE, WAIT_TRIG, CAPTURE, HOLDOFF.
- IDLE:
  - -> WAIT_TRIG if run=1 or single=1; single is latched as a one-shot flag.
- WAIT_TRIG:
  - On entry, prev_valid is cleared.
  - The first accepted sample only loads prev; it never triggers.
  - Rising trigger: prev < trig_level and adc_data >= trig_level.
  - Falling trigger: prev > trig_level and adc_data <= trig_level.
  - Compares are unsigned. trig_level/trig_slope are sampled per sample and are not latched.
  - On trigger, the triggering sample is written to shadow[0], index -> 1, state -> CAPTURE.
- CAPTURE:
  - Each adc_valid writes shadow[index] and increments index.
  - Cycles with adc_valid low stall; no write, no index change.
  - The edge that writes index SAMPLES-1 is edge k, and state -> HOLDOFF at edge k.
  - At edge k+1: data <= entire shadow, frame_valid=1 for exactly one cycle, auto_trig updated.
  - Publish latency: 1 clk after the last sample is written.
- data publishing:
  - data changes only on publish edges; it is never partially updated.
  - data holds the previous frame throughout WAIT_TRIG and CAPTURE.
- HOLDOFF:
  - Counts HOLDOFF cycles; samples are ignored.
  - At terminal count: -> WAIT_TRIG if run=1 and no one-shot is pending; else -> IDLE, clearing the one-shot flag.
- run deasserted mid-frame:
  - WAIT_TRIG -> IDLE on the next edge unless single mode is active.
  - CAPTURE always completes and publishes.
- single asserted while busy: ignored.
- Index width: clog2(SAMPLES); no wrap, since capture ends exactly at SAMPLES-1.
- Sample timing: adc_valid on the same cycle as a state transition is evaluated by the current state only.

Optional Feature:
- Macro: SCOPE_CAPTURE_TRIG_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_TRIG and is cleared on entry.
  - On reaching TIMEOUT, the next accepted sample is treated as a trigger, even if prev_valid=0.
  - That frame publishes with auto_trig=1; real-trigger frames publish with auto_trig=0.
- When undefined: no counter logic exists, auto_trig is tied 0, and WAIT_TRIG waits indefinitely.

Test Plan:
- Reset mid-CAPTURE (index=200), held 1 cycle -> next cycle state=IDLE, busy=0, frame_valid=0, data[0..511]=0.
- run=1, level=2048, rising; ramp adc_data=0,16,32,... with adc_valid every cycle -> data[0]=2048, data[1]=2064, data[255]=6128 mod 4096=2032; frame_valid pulses once, 1 clk after the 512th capture write.
- Falling slope, level=1000, samples 1200,1100,1000,900 -> trigger on 1000, data[0]=1000, data[1]=900; sample 1100 does not trigger.
- adc_valid 1-in-4 during capture -> still exactly 512 samples, in order; frame_valid only after the 512th valid; data unchanged until then.
- single pulse with run=0 -> exactly one frame_valid, then IDLE after HOLDOFF=1000 cycles; busy=0; a second single during HOLDOFF is ignored.
- With SCOPE_CAPTURE_TRIG_TIMEOUT_EN, TIMEOUT=100, constant input 500, level=2048 -> publish with data[*]=500, auto_trig=1; without the macro, no frame_valid within 10000 cycles.
